// File: rtl/astropix_layer_emulator.sv
// AstroPix chip-side emulator: buffers AXI-Stream readout frames and shifts them out
// on 2-bit MISO to the layer SPI master, deserialising MOSI into configuration bytes.
module astropix_layer_emulator #(
   parameter int unsigned LAYER_ID  = 0,
   parameter int unsigned AWIDTH    = 6,
   parameter logic [7:0]  IDLE_BYTE = 8'hBC
) (
   input  logic        clk_core,
   input  logic        clk_core_rst,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tvalid,
   output logic        s_axis_tready,
   input  logic        spi_clk,
   input  logic        spi_csn,
   input  logic        spi_mosi,
   output logic [1:0]  spi_miso,
   output logic        interruptn,
   output logic [7:0]  mosi_m_axis_tdata,
   output logic        mosi_m_axis_tvalid,
   output logic [31:0] stat_frames_sent,
   output logic [7:0]  stat_layer_id
);

   localparam int unsigned DEPTH = 1 << AWIDTH;
   localparam int unsigned CW    = AWIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SHIFT
   } tx_state_e;

   // ---------------------------------------------------------------------------
   // SPI input synchronisers: [0],[1] are the 2-FF synchroniser, [2] the edge register.
   // ---------------------------------------------------------------------------
   logic [2:0] sclk_sync_q;
   logic [2:0] csn_sync_q;
   logic [2:0] mosi_sync_q;

   // NOTE: the synchronisers are deliberately left out of reset so that a chip select
   // already low when reset is released does not produce a spurious falling edge.
   always_ff @(posedge clk_core) begin
      sclk_sync_q <= {sclk_sync_q[1:0], spi_clk};
      csn_sync_q  <= {csn_sync_q[1:0],  spi_csn};
      mosi_sync_q <= {mosi_sync_q[1:0], spi_mosi};
   end

   logic sclk_rise, sclk_fall, csn_fall, csn_rise, csn_low, mosi_bit;

   assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
   assign csn_rise  = csn_sync_q[1] & ~csn_sync_q[2];
   assign csn_low   = ~csn_sync_q[1];
   assign mosi_bit  = mosi_sync_q[2];

   // ---------------------------------------------------------------------------
   // Frame buffer
   // ---------------------------------------------------------------------------
   logic [8:0]        mem_q [DEPTH];
   logic [AWIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]     count_q, count_d;
   logic [CW-1:0]     frames_q, frames_d;
   logic              tready_q, tready_d;
   logic              wr_en, pop;
   logic [8:0]        head;

   assign wr_en = s_axis_tvalid & tready_q;
   assign head  = mem_q[rd_ptr_q];

   // NOTE: storage is not reset; the pointers and count alone define what is valid.
   always_ff @(posedge clk_core) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {s_axis_tlast, s_axis_tdata};
      end
   end

   assign count_d  = count_q + CW'(wr_en) - CW'(pop);
   assign frames_d = frames_q + CW'(wr_en & s_axis_tlast) - CW'(pop & head[8]);
   assign tready_d = (count_d != CW'(DEPTH));

   // ---------------------------------------------------------------------------
   // TX state machine and next-byte selection
   // ---------------------------------------------------------------------------
   tx_state_e   state_q, state_d;
   logic [7:0]  shreg_q, shreg_d;
   logic [1:0]  bitcnt_q, bitcnt_d;
   logic [7:0]  hold_q, hold_d;
   logic        hold_tlast_q, hold_tlast_d;
   logic        hold_valid_q, hold_valid_d;
   logic        in_frame_q, in_frame_d;
   logic        select_next;
   logic        frame_done;
   logic        interruptn_q;
   logic [31:0] frames_sent_q;

   // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      bitcnt_d     = bitcnt_q;
      hold_d       = hold_q;
      hold_tlast_d = hold_tlast_q;
      hold_valid_d = hold_valid_q;
      in_frame_d   = in_frame_q;
      select_next  = 1'b0;
      frame_done   = 1'b0;
      pop          = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (csn_fall) begin
               state_d     = ST_LOAD;
               select_next = ~hold_valid_q;
            end
         end
         ST_LOAD: begin
            shreg_d  = hold_q;
            bitcnt_d = 2'd0;
            state_d  = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (sclk_fall) begin
               shreg_d  = {2'b00, shreg_q[7:2]};
               bitcnt_d = bitcnt_q + 2'd1;
               if (bitcnt_q == 2'd3) begin
                  frame_done   = hold_tlast_q;
                  hold_valid_d = 1'b0;
                  select_next  = 1'b1;
                  state_d      = ST_LOAD;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // An open frame keeps draining even if its tlast has not arrived yet.
      if (select_next) begin
         hold_valid_d = 1'b1;
         if (((frames_q != '0) || in_frame_q) && (count_q != '0)) begin
            pop          = 1'b1;
            hold_d       = head[7:0];
            hold_tlast_d = head[8];
            in_frame_d   = ~head[8];
         end else begin
            hold_d       = IDLE_BYTE;
            hold_tlast_d = 1'b0;
         end
      end

      if (csn_rise) begin
         state_d  = ST_IDLE;
         bitcnt_d = 2'd0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples values from before the edge regardless of statement order.
   always_ff @(posedge clk_core) begin
      if (clk_core_rst) begin
         state_q       <= ST_IDLE;
         shreg_q       <= '0;
         bitcnt_q      <= '0;
         hold_q        <= '0;
         hold_tlast_q  <= 1'b0;
         hold_valid_q  <= 1'b0;
         in_frame_q    <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
         frames_q      <= '0;
         tready_q      <= 1'b0;
         interruptn_q  <= 1'b1;
         frames_sent_q <= '0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         bitcnt_q     <= bitcnt_d;
         hold_q       <= hold_d;
         hold_tlast_q <= hold_tlast_d;
         hold_valid_q <= hold_valid_d;
         in_frame_q   <= in_frame_d;
         count_q      <= count_d;
         frames_q     <= frames_d;
         tready_q     <= tready_d;
         interruptn_q <= ~((frames_q != '0) || in_frame_q);
         if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + AWIDTH'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AWIDTH'(1);
         end
         if (frame_done) begin
            frames_sent_q <= frames_sent_q + 32'd1;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // RX deserialiser (LSB first); partial bytes are dropped when csn goes high.
   // ---------------------------------------------------------------------------
   logic [7:0] rxreg_q;
   logic [2:0] rxcnt_q;
   logic [7:0] rx_tdata_q;
   logic       rx_tvalid_q;

   always_ff @(posedge clk_core) begin
      if (clk_core_rst) begin
         rxreg_q     <= '0;
         rxcnt_q     <= '0;
         rx_tdata_q  <= '0;
         rx_tvalid_q <= 1'b0;
      end else begin
         rx_tvalid_q <= 1'b0;
         if (!csn_low) begin
            rxcnt_q <= '0;
         end else if (sclk_rise) begin
            rxreg_q <= {mosi_bit, rxreg_q[7:1]};
            rxcnt_q <= rxcnt_q + 3'd1;
            if (rxcnt_q == 3'd7) begin
               rx_tdata_q  <= {mosi_bit, rxreg_q[7:1]};
               rx_tvalid_q <= 1'b1;
            end
         end
      end
   end

   assign s_axis_tready      = tready_q;
   assign spi_miso           = (state_q == ST_SHIFT) ? shreg_q[1:0] : 2'b00;
   assign interruptn         = interruptn_q;
   assign mosi_m_axis_tdata  = rx_tdata_q;
   assign mosi_m_axis_tvalid = rx_tvalid_q;
   assign stat_frames_sent   = frames_sent_q;
   assign stat_layer_id      = 8'(LAYER_ID);

endmodule
